// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared types and burst helpers for the AXI3 slave memory
//
// Burst/response encodings, write/read FSM states, and the step/wrap/header
// checks used by both channels.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    function automatic logic [31:0] burst_step(input logic [2:0] size);
        return 32'd1 << size;
    endfunction

    function automatic logic [31:0] wrap_boundary(input logic [3:0] len, input logic [2:0] size);
        return ({28'd0, len} + 32'd1) << size;
    endfunction

    // Address-phase checks that make a whole burst SLVERR: oversize beats,
    // the reserved burst type, and WRAP lengths that are not a power of two.
    function automatic logic hdr_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
        logic bad_wrap;
        bad_wrap = (burst_e'(burst) == BURST_WRAP) &&
                   !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (size > 3'd2) || (burst == 2'd3) || bad_wrap;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - combinational next-beat address for one AXI channel
//
// Ports: addr (current beat byte address), size (log2 bytes/beat),
// len (beats-1), burst (FIXED/INCR/WRAP) -> next_addr.
module axi_burst_addr
    import axi_mem_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [3:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] mask;

    always_comb begin
        step = burst_step(size);
        mask = wrap_boundary(len, size) - 32'd1;
        case (burst_e'(burst))
            BURST_INCR: next_addr = addr + step;
            // Keep the bits above the wrap window, let the low bits roll over.
            BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 slave backed by a word-addressed memory array
//
// Ports: clk, rstn (sync active-low); AW channel (awvalid/awready, awid,
// awlen, awsize, awaddr, awburst); W channel (wvalid/wready, wid, wdata,
// wstrb, wlast); B channel (bvalid/bready, bid, bresp); AR channel
// (arvalid/arready, arid, araddr, arlen, arsize, arburst); R channel
// (rvalid/rready, rid, rdata, rstrb, rresp, rlast).
module axi_slave_mem
    import axi_mem_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [31:0] awaddr,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [3:0]  rstrb,
    output logic [1:0]  rresp,
    output logic        rlast
);

    localparam int          IDXW      = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

    logic [31:0] mem [DEPTH];

    // ---------------- write path ----------------
    wstate_e     wstate, wstate_nx;
    logic [3:0]  awid_q, wlen_q, wcnt_q;
    logic [2:0]  wsize_q;
    logic [1:0]  wburst_q;
    logic [31:0] waddr_q, waddr_nx;
    logic        wslv_q, wdec_q;
    logic        w_fire, w_last_due, w_beat_slv, w_beat_dec, w_we;
    logic [IDXW-1:0] widx;

    axi_burst_addr u_waddr (
        .addr      (waddr_q),
        .size      (wsize_q),
        .len       (wlen_q),
        .burst     (wburst_q),
        .next_addr (waddr_nx)
    );

    always_comb begin
        w_fire     = (wstate == W_DATA) && wvalid;
        w_last_due = (wcnt_q == wlen_q);
        // Wrong ID, early wlast, or missing wlast on the final beat.
        w_beat_slv = (wid != awid_q) || (wlast != w_last_due);
        w_beat_dec = (waddr_q >= MEM_BYTES);
        // Once any error is seen (including on this beat) nothing more is written.
        w_we       = w_fire && !w_beat_slv && !w_beat_dec && !wslv_q && !wdec_q;
        widx       = waddr_q[IDXW+1:2];
    end

    always_comb begin
        wstate_nx = wstate;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bid       = '0;
        bresp     = RESP_OKAY;
        case (wstate)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) wstate_nx = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (wlast || w_last_due)) wstate_nx = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bid    = awid_q;
                bresp  = wdec_q ? RESP_DECERR : (wslv_q ? RESP_SLVERR : RESP_OKAY);
                if (bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) wstate <= W_IDLE;
        else       wstate <= wstate_nx;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            awid_q   <= '0;
            wlen_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            waddr_q  <= '0;
            wcnt_q   <= '0;
            wslv_q   <= 1'b0;
            wdec_q   <= 1'b0;
        end else if (wstate == W_IDLE && awvalid) begin
            awid_q   <= awid;
            wlen_q   <= awlen;
            wsize_q  <= awsize;
            wburst_q <= awburst;
            waddr_q  <= awaddr;
            wcnt_q   <= '0;
            wslv_q   <= hdr_err(awsize, awburst, awlen);
            wdec_q   <= 1'b0;
        end else if (w_fire) begin
            waddr_q  <= waddr_nx;
            wcnt_q   <= wcnt_q + 4'd1;
            wslv_q   <= wslv_q | w_beat_slv;
            wdec_q   <= wdec_q | w_beat_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rstate_e     rstate, rstate_nx;
    logic [3:0]  arid_q, rlen_q, rcnt_q;
    logic [2:0]  rsize_q;
    logic [1:0]  rburst_q;
    logic [31:0] raddr_q, raddr_nx;
    logic        rhdr_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        r_last, r_load, rd_hdr;
    logic [31:0] rd_addr;
    logic [1:0]  rd_resp;
    logic [IDXW-1:0] ridx;

    axi_burst_addr u_raddr (
        .addr      (raddr_q),
        .size      (rsize_q),
        .len       (rlen_q),
        .burst     (rburst_q),
        .next_addr (raddr_nx)
    );

    // rdata is registered: the word for the upcoming beat is fetched on the
    // edge that accepts AR (from araddr) or the edge that accepts a beat
    // (from the next address). Sampling mem with <= yields pre-write data.
    always_comb begin
        r_last = (rcnt_q == rlen_q);
        if (rstate == R_IDLE) begin
            rd_addr = araddr;
            rd_hdr  = hdr_err(arsize, arburst, arlen);
            r_load  = arvalid;
        end else begin
            rd_addr = raddr_nx;
            rd_hdr  = rhdr_q;
            r_load  = rready;
        end
        rd_resp = (rd_addr >= MEM_BYTES) ? RESP_DECERR : (rd_hdr ? RESP_SLVERR : RESP_OKAY);
        ridx    = rd_addr[IDXW+1:2];
    end

    always_comb begin
        rstate_nx = rstate;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rid       = '0;
        rdata     = '0;
        rstrb     = '0;
        rresp     = RESP_OKAY;
        rlast     = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) rstate_nx = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rid    = arid_q;
                rdata  = rdata_q;
                rstrb  = 4'hF;
                rresp  = rresp_q;
                rlast  = r_last;
                if (rready && r_last) rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) rstate <= R_IDLE;
        else       rstate <= rstate_nx;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            arid_q   <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            raddr_q  <= '0;
            rcnt_q   <= '0;
            rhdr_q   <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            if (rstate == R_IDLE && arvalid) begin
                arid_q   <= arid;
                rlen_q   <= arlen;
                rsize_q  <= arsize;
                rburst_q <= arburst;
                raddr_q  <= araddr;
                rcnt_q   <= '0;
                rhdr_q   <= hdr_err(arsize, arburst, arlen);
            end else if (rstate == R_DATA && rready) begin
                raddr_q  <= raddr_nx;
                rcnt_q   <= rcnt_q + 4'd1;
            end
            if (r_load) begin
                rresp_q <= rd_resp;
                rdata_q <= (rd_resp == RESP_OKAY) ? mem[ridx] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - directed self-checking bench for axi_slave_mem
module tb_axi_slave_mem;

    logic        clk = 1'b0;
    logic        rstn;
    logic        awvalid, awready;
    logic [3:0]  awid, awlen;
    logic [2:0]  awsize;
    logic [31:0] awaddr;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [3:0]  arid, arlen;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [3:0]  rid, rstrb;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rexp [16];

    axi_slave_mem #(.DEPTH(128)) dut (
        .clk(clk), .rstn(rstn),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awaddr(awaddr), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rstrb(rstrb), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok;
        int   n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = awready;
            @(posedge clk); #1; n++;
        end
        awvalid = 1'b0;
        check("aw_handshake", 32'(ok), 32'd1);
    endtask

    task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input logic stall);
        logic ok;
        int   n;
        if (stall) begin
            wvalid = 1'b0;
            @(posedge clk); #1;
        end
        wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = wready;
            @(posedge clk); #1; n++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_handshake", 32'(ok), 32'd1);
    endtask

    task automatic b_wait(input logic [3:0] exp_id, input logic [1:0] exp_resp, input string tag);
        logic       ok;
        logic [3:0] gid;
        logic [1:0] gresp;
        int         n;
        bready = 1'b1; ok = 1'b0; n = 0; gid = '0; gresp = '0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; gid = bid; gresp = bresp; end
            @(posedge clk); #1; n++;
        end
        bready = 1'b0;
        check({tag, "_bvalid"}, 32'(ok), 32'd1);
        check({tag, "_bresp"}, 32'(gresp), 32'(exp_resp));
        check({tag, "_bid"}, 32'(gid), 32'(exp_id));
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input logic [31:0] base, input int early, input logic [1:0] exp_resp,
                            input logic stalls, input string tag);
        int nb;
        aw_send(id, addr, len, size, burst);
        nb = (early >= 0) ? early + 1 : int'(len) + 1;
        for (int i = 0; i < nb; i++)
            w_beat(id, base + 32'(i), strb, i == nb - 1, stalls && ($urandom_range(0, 2) == 0));
        b_wait(id, exp_resp, tag);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] exp_resp, input logic stalls, input string tag);
        logic        ok;
        logic [31:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  gid;
        int          n;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk); ok = arready;
            @(posedge clk); #1; n++;
        end
        arvalid = 1'b0;
        check({tag, "_ar"}, 32'(ok), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            ok = 1'b0; n = 0; d = '0; rs = '0; l = 1'b0; gid = '0;
            while (!ok && n < 100) begin
                rready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
                @(negedge clk);
                if (rvalid && rready) begin ok = 1'b1; d = rdata; rs = rresp; l = rlast; gid = rid; end
                @(posedge clk); #1; n++;
            end
            check($sformatf("%s_rbeat%0d", tag, i), 32'(ok), 32'd1);
            check($sformatf("%s_rdata%0d", tag, i), d, rexp[i]);
            check($sformatf("%s_rresp%0d", tag, i), 32'(rs), 32'(exp_resp));
            check($sformatf("%s_rlast%0d", tag, i), 32'(l), 32'(i == int'(len)));
            check($sformatf("%s_rid%0d", tag, i), 32'(gid), 32'(id));
        end
        rready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        awvalid = 0; awid = 0; awlen = 0; awsize = 0; awaddr = 0; awburst = 0;
        wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rstrb", 32'(rstrb), 32'd0);
        rstn = 1'b1;

        // INCR write/read
        do_write(4'h5, 32'h10, 4'd3, 3'd2, 2'd1, 4'hF, 32'hA0, -1, OKAY, 1'b0, "incr_w");
        rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
        do_read(4'h6, 32'h10, 4'd3, 3'd2, 2'd1, OKAY, 1'b0, "incr_r");

        // WRAP write at 0x18: beats land at 0x18, 0x1C, 0x10, 0x14
        do_write(4'h7, 32'h18, 4'd3, 3'd2, 2'd2, 4'hF, 32'hB0, -1, OKAY, 1'b0, "wrap_w");
        rexp[0] = 32'hB0; rexp[1] = 32'hB1; rexp[2] = 32'hB2; rexp[3] = 32'hB3;
        do_read(4'h8, 32'h18, 4'd3, 3'd2, 2'd2, OKAY, 1'b0, "wrap_r");
        rexp[0] = 32'hB2; rexp[1] = 32'hB3; rexp[2] = 32'hB0; rexp[3] = 32'hB1;
        do_read(4'h8, 32'h10, 4'd3, 3'd2, 2'd1, OKAY, 1'b0, "wrap_incr_r");

        // Partial strobe
        do_write(4'h1, 32'h40, 4'd0, 3'd2, 2'd1, 4'hF, 32'h0, -1, OKAY, 1'b0, "strb_clr");
        do_write(4'h1, 32'h40, 4'd0, 3'd2, 2'd1, 4'b0011, 32'hDEADBEEF, -1, OKAY, 1'b0, "strb_w");
        rexp[0] = 32'h0000BEEF;
        do_read(4'h2, 32'h40, 4'd0, 3'd2, 2'd1, OKAY, 1'b0, "strb_r");

        // Out of range: DECERR, and no aliasing into word 0
        do_write(4'h3, 32'h0, 4'd0, 3'd2, 2'd1, 4'hF, 32'h11111111, -1, OKAY, 1'b0, "w0_init");
        do_write(4'hC, 32'h200, 4'd0, 3'd2, 2'd1, 4'hF, 32'h99, -1, DECERR, 1'b0, "dec_w");
        rexp[0] = 32'h11111111;
        do_read(4'h3, 32'h0, 4'd0, 3'd2, 2'd1, OKAY, 1'b0, "dec_w0_r");
        rexp[0] = 32'h0;
        do_read(4'hD, 32'h200, 4'd0, 3'd2, 2'd1, DECERR, 1'b0, "dec_r");

        // Reserved burst and oversize beat: SLVERR, no write
        do_write(4'h4, 32'h20, 4'd0, 3'd2, 2'd1, 4'hF, 32'h2020, -1, OKAY, 1'b0, "slv_init");
        do_write(4'h4, 32'h20, 4'd0, 3'd2, 2'd3, 4'hF, 32'h77, -1, SLVERR, 1'b0, "slv_burst");
        do_write(4'h4, 32'h20, 4'd0, 3'd3, 2'd1, 4'hF, 32'h78, -1, SLVERR, 1'b0, "slv_size");
        rexp[0] = 32'h2020;
        do_read(4'h4, 32'h20, 4'd0, 3'd2, 2'd1, OKAY, 1'b0, "slv_r");

        // Early wlast on beat 2 of a 4-beat burst: first beat committed
        do_write(4'h5, 32'h60, 4'd3, 3'd2, 2'd1, 4'hF, 32'h600, -1, OKAY, 1'b0, "early_init");
        do_write(4'h5, 32'h60, 4'd3, 3'd2, 2'd1, 4'hF, 32'hE00, 1, SLVERR, 1'b0, "early_w");
        rexp[0] = 32'hE00;
        do_read(4'h5, 32'h60, 4'd0, 3'd2, 2'd1, OKAY, 1'b0, "early_r");

        // Concurrent write and read with stalls
        rexp[0] = 32'hB2; rexp[1] = 32'hB3; rexp[2] = 32'hB0; rexp[3] = 32'hB1;
        fork
            do_write(4'h3, 32'h80, 4'd7, 3'd2, 2'd1, 4'hF, 32'hC0, -1, OKAY, 1'b1, "conc_w");
            do_read(4'h4, 32'h10, 4'd3, 3'd2, 2'd1, OKAY, 1'b1, "conc_r");
        join
        for (int i = 0; i < 8; i++) rexp[i] = 32'hC0 + 32'(i);
        do_read(4'hE, 32'h80, 4'd7, 3'd2, 2'd1, OKAY, 1'b1, "conc_back");

        // Reset mid-burst on both channels
        aw_send(4'h9, 32'h100, 4'd7, 3'd2, 2'd1);
        w_beat(4'h9, 32'h5100, 4'hF, 1'b0, 1'b0);
        w_beat(4'h9, 32'h5101, 4'hF, 1'b0, 1'b0);
        arid = 4'h1; araddr = 32'h0; arlen = 4'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("mid_rvalid", 32'(rvalid), 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("mid_awready", 32'(awready), 32'd1);
        check("mid_wready", 32'(wready), 32'd0);
        check("mid_bvalid", 32'(bvalid), 32'd0);
        check("mid_arready", 32'(arready), 32'd1);
        check("mid_rvalid_rst", 32'(rvalid), 32'd0);
        check("mid_rdata_rst", rdata, 32'd0);
        rstn = 1'b1;
        rexp[0] = 32'h5100; rexp[1] = 32'h5101;
        do_read(4'h2, 32'h100, 4'd1, 3'd2, 2'd1, OKAY, 1'b0, "mid_partial");
        do_write(4'hA, 32'h100, 4'd1, 3'd2, 2'd1, 4'hF, 32'h6100, -1, OKAY, 1'b0, "post_w");
        rexp[0] = 32'h6100; rexp[1] = 32'h6101;
        do_read(4'hB, 32'h100, 4'd1, 3'd2, 2'd1, OKAY, 1'b0, "post_r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
